// File: rtl/sha_mem_arbiter_if.sv
// Bus bundle between the SHA engines, the shared memory port and the arbiter.
// The arbiter uses the slave modport; engines plus memory use the master modport.
interface sha_mem_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 32
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        req_we;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        rd_valid;
  logic [DATA_W-1:0]         rd_data;
  logic                      mem_we;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_write_data;
  logic [DATA_W-1:0]         mem_read_data;

  modport slave (
    input  req, req_we, req_addr, req_wdata, mem_read_data,
    output gnt, rd_valid, rd_data, mem_we, mem_addr, mem_write_data
  );

  modport master (
    output req, req_we, req_addr, req_wdata, mem_read_data,
    input  gnt, rd_valid, rd_data, mem_we, mem_addr, mem_write_data
  );
endinterface

// File: rtl/sha_mem_arbiter.sv
// Round-robin arbiter for the shared SHA message/hash memory port, with a
// per-tenure beat cap and owner-tagged read return.
module sha_mem_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  output logic               o_mem_clk,
  sha_mem_arbiter_if.slave   bus
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [0:0] {StIdle, StOwn} state_e;

  state_e              r_state, w_state_d;
  logic [NUM_REQ-1:0]  r_gnt, w_gnt_d;
  logic [NUM_REQ-1:0]  r_rd_valid, w_rd_valid_d;
  logic [IdxW-1:0]     r_owner, w_owner_d;
  logic [IdxW-1:0]     r_rr, w_rr_d;
  logic [4:0]          r_beat, w_beat_d;

  logic                w_req_k;
  logic                w_we_k;
  logic [ADDR_W-1:0]   w_addr_k;
  logic [DATA_W-1:0]   w_wdata_k;
  logic                w_beat;
  logic                w_end;
  logic [IdxW-1:0]     w_next_k;
  logic [IdxW-1:0]     w_start;
  logic                w_grant;
  logic [IdxW-1:0]     w_winner;

  // First requester at or after start, wrapping modulo NUM_REQ.
  function automatic logic [IdxW-1:0] pick_winner(input logic [NUM_REQ-1:0] req,
                                                  input logic [IdxW-1:0]    start);
    logic [IdxW-1:0] win;
    logic            found;
    int unsigned     j;
    win   = start;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      j = (int'(start) + i) % NUM_REQ;
      if (!found && req[j]) begin
        found = 1'b1;
        win   = IdxW'(j);
      end
    end
    return win;
  endfunction

  assign w_req_k   = bus.req[r_owner];
  assign w_we_k    = bus.req_we[r_owner];
  assign w_addr_k  = bus.req_addr[int'(r_owner)*ADDR_W +: ADDR_W];
  assign w_wdata_k = bus.req_wdata[int'(r_owner)*DATA_W +: DATA_W];
  assign w_beat    = (r_state == StOwn) && w_req_k;
  assign w_end     = (r_state == StOwn) &&
                     (!w_req_k || (w_beat && (r_beat == 5'(MAX_BURST - 1))));
  assign w_next_k  = (r_owner == IdxW'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;
  assign w_start   = (r_state == StOwn) ? w_next_k : r_rr;
  assign w_winner  = pick_winner(bus.req, w_start);
  assign w_grant   = (|bus.req) && ((r_state == StIdle) || w_end);

  always_comb begin
    w_state_d    = r_state;
    w_gnt_d      = r_gnt;
    w_owner_d    = r_owner;
    w_rr_d       = r_rr;
    w_beat_d     = r_beat;
    w_rd_valid_d = '0;

    if (w_beat && !w_we_k) begin
      w_rd_valid_d = NUM_REQ'(1) << r_owner;
    end

    unique case (r_state)
      StIdle: ;
      StOwn: begin
        if (w_end) begin
          w_rr_d = w_next_k;
          if (!w_grant) begin
            w_state_d = StIdle;
            w_gnt_d   = '0;
            w_beat_d  = '0;
          end
        end else if (w_beat) begin
          w_beat_d = (r_beat == 5'h1f) ? r_beat : r_beat + 5'd1;
        end
      end
      default: w_state_d = StIdle;
    endcase

    // A preempted owner is searched last because the scan starts at owner+1.
    if (w_grant) begin
      w_state_d = StOwn;
      w_owner_d = w_winner;
      w_gnt_d   = NUM_REQ'(1) << w_winner;
      w_beat_d  = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state    <= StIdle;
      r_gnt      <= '0;
      r_rd_valid <= '0;
      r_owner    <= '0;
      r_rr       <= '0;
      r_beat     <= '0;
    end else begin
      r_state    <= w_state_d;
      r_gnt      <= w_gnt_d;
      r_rd_valid <= w_rd_valid_d;
      r_owner    <= w_owner_d;
      r_rr       <= w_rr_d;
      r_beat     <= w_beat_d;
    end
  end

  assign o_mem_clk          = i_clk;
  assign bus.gnt            = r_gnt;
  assign bus.rd_valid       = r_rd_valid;
  assign bus.rd_data        = bus.mem_read_data;
  assign bus.mem_we         = w_beat && w_we_k;
  assign bus.mem_addr       = (r_state == StOwn) ? w_addr_k : '0;
  assign bus.mem_write_data = (r_state == StOwn) ? w_wdata_k : '0;

endmodule

// File: tb/tb_sha_mem_arbiter.sv
// Random-traffic bench for sha_mem_arbiter: engines issue random bursts against a
// tenure-level reference model of grants, port muxing and read return.
module tb_sha_mem_arbiter;
  localparam int NReq   = 4;
  localparam int AddrW  = 16;
  localparam int DataW  = 32;
  localparam int MaxB   = 16;
  localparam int WaitMx = (NReq - 1) * (MaxB + 1) + 1;

  logic clk;
  logic reset_n;
  logic mem_clk;
  bit   mem_init_done;
  logic [DataW-1:0] tb_mem [256];

  sha_mem_arbiter_if #(.NUM_REQ(NReq), .ADDR_W(AddrW), .DATA_W(DataW)) bus ();

  sha_mem_arbiter #(
    .NUM_REQ(NReq), .ADDR_W(AddrW), .DATA_W(DataW), .MAX_BURST(MaxB)
  ) dut (
    .i_clk    (clk),
    .i_reset_n(reset_n),
    .o_mem_clk(mem_clk),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DataW-1:0] mem_init(input int i);
    return 32'(i) * 32'h9E37_79B9 ^ 32'h5A5A_0000;
  endfunction

  // Synchronous memory: one-cycle read latency, write on mem_we.
  always @(posedge mem_clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 256; i++) tb_mem[i] <= mem_init(i);
      mem_init_done <= 1'b1;
    end else if (bus.mem_we) begin
      tb_mem[bus.mem_addr[7:0]] <= bus.mem_write_data;
    end
    bus.mem_read_data <= tb_mem[bus.mem_addr[7:0]];
  end

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Engine stimulus state
  int              rem    [NReq];
  logic [7:0]      e_addr [NReq];
  logic [NReq-1:0] e_beat;
  int              waitc  [NReq];

  // Reference model state
  int              m_owner;
  int              m_rr;
  int              m_beats;
  logic [NReq-1:0] m_rdv;
  logic [DataW-1:0] m_rdexp;
  logic [DataW-1:0] mm [256];

  function automatic int first_from(input logic [NReq-1:0] r, input int start);
    for (int i = 0; i < NReq; i++) begin
      if (r[(start + i) % NReq]) return (start + i) % NReq;
    end
    return -1;
  endfunction

  task automatic drive_engines();
    for (int k = 0; k < NReq; k++) begin
      if (e_beat[k]) begin
        rem[k]--;
        e_addr[k]++;
      end
      if (rem[k] == 0 && $urandom_range(0, 3) == 0) begin
        rem[k]    = $urandom_range(1, 24);
        e_addr[k] = 8'($urandom_range(0, 255));
      end
      bus.req[k]                       = (rem[k] > 0);
      bus.req_we[k]                    = 1'($urandom_range(0, 1));
      bus.req_addr[k*AddrW +: AddrW]   = {8'h00, e_addr[k]};
      bus.req_wdata[k*DataW +: DataW]  = $urandom;
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_rr    = 0;
    m_beats = 0;
    m_rdv   = '0;
    e_beat  = '0;
    for (int k = 0; k < NReq; k++) waitc[k] = 0;
  endtask

  task automatic model_step();
    logic [NReq-1:0] r;
    logic            beat;
    logic            exp_we;
    logic [AddrW-1:0] exp_addr;
    logic [DataW-1:0] exp_wd;
    r        = bus.req;
    beat     = (m_owner >= 0) && r[m_owner];
    exp_we   = 1'b0;
    exp_addr = '0;
    exp_wd   = '0;
    if (m_owner >= 0) begin
      exp_addr = bus.req_addr[m_owner*AddrW +: AddrW];
      exp_wd   = bus.req_wdata[m_owner*DataW +: DataW];
      exp_we   = beat && bus.req_we[m_owner];
    end
    check_eq("gnt", 64'(bus.gnt), (m_owner < 0) ? 64'd0 : 64'(1) << m_owner);
    check_eq("mem_we", 64'(bus.mem_we), 64'(exp_we));
    check_eq("mem_addr", 64'(bus.mem_addr), 64'(exp_addr));
    if (exp_we) check_eq("mem_wdata", 64'(bus.mem_write_data), 64'(exp_wd));
    check_eq("rd_valid", 64'(bus.rd_valid), 64'(m_rdv));
    if (m_rdv != '0) check_eq("rd_data", 64'(bus.rd_data), 64'(m_rdexp));
    for (int k = 0; k < NReq; k++) begin
      waitc[k] = (r[k] && !bus.gnt[k]) ? waitc[k] + 1 : 0;
      check_eq("wait_bound", 64'(waitc[k] <= WaitMx), 64'd1);
    end

    e_beat = '0;
    m_rdv  = '0;
    if (beat) begin
      e_beat[m_owner] = 1'b1;
      if (exp_we) begin
        mm[exp_addr[7:0]] = exp_wd;
      end else begin
        m_rdv[m_owner] = 1'b1;
        m_rdexp        = mm[exp_addr[7:0]];
      end
    end

    if (m_owner < 0) begin
      if (r != '0) begin
        m_owner = first_from(r, m_rr);
        m_beats = 0;
      end
    end else if (!r[m_owner] || (beat && m_beats == MaxB - 1)) begin
      m_rr    = (m_owner + 1) % NReq;
      m_owner = first_from(r, m_rr);
      m_beats = 0;
    end else if (beat) begin
      m_beats++;
    end
  endtask

  bit did_rst = 1'b0;

  initial begin
    reset_n = 1'b0;
    for (int i = 0; i < 256; i++) mm[i] = mem_init(i);
    for (int k = 0; k < NReq; k++) begin
      rem[k]    = $urandom_range(1, 24);
      e_addr[k] = 8'($urandom_range(0, 255));
    end
    model_reset();
    drive_engines();

    // All engines requesting while held in reset.
    repeat (2) begin
      @(negedge clk);
      check_eq("rst_gnt", 64'(bus.gnt), 64'd0);
      check_eq("rst_we", 64'(bus.mem_we), 64'd0);
      check_eq("rst_rdv", 64'(bus.rd_valid), 64'd0);
    end
    @(posedge clk);
    #2 reset_n = 1'b1;

    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      model_step();
      @(posedge clk);
      #1 drive_engines();
      if (c >= 2000 && !did_rst && m_owner >= 0 && bus.req[m_owner] && !bus.req_we[m_owner]) begin
        did_rst = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        check_eq("mid_rst_gnt", 64'(bus.gnt), 64'd0);
        check_eq("mid_rst_we", 64'(bus.mem_we), 64'd0);
        model_reset();
        @(negedge clk);
        check_eq("mid_rst_rdv0", 64'(bus.rd_valid), 64'd0);
        @(posedge clk);
        #1;
        check_eq("mid_rst_rdv1", 64'(bus.rd_valid), 64'd0);
        drive_engines();
        #1 reset_n = 1'b1;
      end
    end
    check_eq("mid_reset_hit", 64'(did_rst), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
